// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types and constants for the trace capture unit:
//               FSM state encoding, readout beat indices and record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Capture FSM state; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } trace_state_t;

    // Readout beat order within one record
    localparam logic [1:0] BEAT_PC    = 2'd0;
    localparam logic [1:0] BEAT_INSTR = 2'd1;
    localparam logic [1:0] BEAT_ALU   = 2'd2;

    // One record is {PC, instr, ALU result}, PC in the top word
    localparam int REC_W = 96;

    // Select the 32-bit word of a record that belongs to a given beat
    function automatic logic [31:0] beat_word(input logic [REC_W-1:0] rec,
                                              input logic [1:0]       beat);
        logic [31:0] w_word;
        w_word = '0;
        case (beat)
            BEAT_PC:    w_word = rec[95:64];
            BEAT_INSTR: w_word = rec[63:32];
            BEAT_ALU:   w_word = rec[31:0];
            default:    w_word = '0;
        endcase
        return w_word;
    endfunction

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Record buffer for the trace capture unit. Pushes while full
//               are dropped (full is judged before any same-cycle pop);
//               clear flushes pointers and count and overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = REC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full  && !i_clear;
    assign w_do_pop  = i_pop  && !o_empty && !i_clear;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset or clear
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule : trace_fifo
`default_nettype wire

// File: rtl/trace_capture_unit.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_unit
// Description : Arm/trigger/stop capture FSM feeding a record buffer, with a
//               three-beat (PC, instr, ALU) ready/valid readout serializer
//               that runs independently of the capture state.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       alu_result_in,
    input  logic              capture_en,
    input  logic              arm,
    input  logic              stop,
    input  logic              clear,
    input  logic              trig_en,
    input  logic [31:0]       trig_pc,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [1:0]        state
);

    trace_state_t      r_state;
    trace_state_t      w_state_nxt;
    logic [1:0]        r_beat;
    logic              r_overflow;
    logic              w_trig_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [REC_W-1:0]  w_head;

    // Trigger fires on a PC match, or unconditionally when triggering is off
    assign w_trig_hit = !trig_en || (PC_in == trig_pc);

    // The triggering cycle itself is captured, as is the cycle stop arrives
    assign w_push = capture_en &&
                    ((r_state == CAPTURE) || ((r_state == ARMED) && w_trig_hit));

    // A record leaves the buffer when its final beat is accepted
    assign w_pop = rd_valid && rd_ready && (r_beat == BEAT_ALU);

    trace_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (clear),
        .i_push    (w_push),
        .i_wr_data ({PC_in, instr_in, alu_result_in}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state; stop wins over a same-cycle trigger in ARMED
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (arm)             w_state_nxt = ARMED;
            ARMED:   if (stop)            w_state_nxt = IDLE;
                     else if (w_trig_hit) w_state_nxt = CAPTURE;
            CAPTURE: if (stop)            w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Beat counter steps on every accepted beat and wraps after the ALU beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_beat <= BEAT_PC;
        else if (clear)               r_beat <= BEAT_PC;
        else if (rd_valid && rd_ready) r_beat <= (r_beat == BEAT_ALU) ? BEAT_PC
                                                                      : r_beat + 2'd1;
    end

    // Sticky overflow: a qualified record arrived while the buffer was full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_overflow <= 1'b0;
        else if (clear)             r_overflow <= 1'b0;
        else if (w_push && w_full)  r_overflow <= 1'b1;
    end

    // Readout beat selection, forced to zero when nothing is buffered
    always_comb begin
        rd_valid = !w_empty;
        rd_last  = rd_valid && (r_beat == BEAT_ALU);
        rd_data  = rd_valid ? beat_word(w_head, r_beat) : 32'd0;
    end

    assign full     = w_full;
    assign overflow = r_overflow;
    assign state    = r_state;

endmodule : trace_capture_unit
`default_nettype wire

// File: tb/tb_trace_capture_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_capture_unit
// Description : Directed plus randomized bench for trace_capture_unit with a
//               queue-based reference model of the capture/readout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_capture_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC_in, instr_in, alu_result_in, trig_pc;
    logic        capture_en, arm, stop, clear, trig_en, rd_ready;
    logic        rd_valid, rd_last, full, overflow;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Reference model: buffered records, current beat, sticky flag, state
    logic [95:0] mq[$];
    int          m_st;
    int          m_beat;
    bit          m_ovf;

    trace_capture_unit #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_in         (PC_in),
        .instr_in      (instr_in),
        .alu_result_in (alu_result_in),
        .capture_en    (capture_en),
        .arm           (arm),
        .stop          (stop),
        .clear         (clear),
        .trig_en       (trig_en),
        .trig_pc       (trig_pc),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_st   = 0;
        m_beat = 0;
        m_ovf  = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit trig, push, valid, pop, was_full;
        trig     = !trig_en || (PC_in == trig_pc);
        push     = capture_en && (m_st == 2 || (m_st == 1 && trig));
        valid    = (mq.size() != 0);
        pop      = valid && rd_ready && (m_beat == 2);
        was_full = (mq.size() == DEPTH);
        if (clear) begin
            mq.delete();
            m_beat = 0;
            m_ovf  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (was_full) m_ovf = 1;
                else          mq.push_back({PC_in, instr_in, alu_result_in});
            end
            if (valid && rd_ready) m_beat = (m_beat + 1) % 3;
        end
        case (m_st)
            0: if (arm) m_st = 1;
            1: if (stop) m_st = 0; else if (trig) m_st = 2;
            2: if (stop) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic check_model();
        bit          v;
        logic [95:0] head;
        logic [31:0] d;
        v = (mq.size() != 0);
        d = 32'd0;
        if (v) begin
            head = mq[0];
            d    = head[95 - 32*m_beat -: 32];
        end
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, v});
        chk("rd_data",  rd_data, d);
        chk("rd_last",  {31'd0, rd_last}, {31'd0, (v && m_beat == 2)});
        chk("count",    {27'd0, count}, mq.size());
        chk("full",     {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("state",    {30'd0, state}, m_st);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_rec(input logic [31:0] pc);
        PC_in         = pc;
        instr_in      = 32'hA000_0000 ^ pc;
        alu_result_in = 32'hB000_0000 ^ pc;
    endtask

    task automatic pulse_arm();   arm = 1'b1;   tick(); arm = 1'b0;   endtask
    task automatic pulse_stop();  stop = 1'b1;  tick(); stop = 1'b0;  endtask
    task automatic pulse_clear(); clear = 1'b1; tick(); clear = 1'b0; endtask

    initial begin
        rst_n = 1'b0; PC_in = '0; instr_in = '0; alu_result_in = '0; trig_pc = '0;
        capture_en = 0; arm = 0; stop = 0; clear = 0; trig_en = 0; rd_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_model();

        // Immediate trigger, three records, nine-beat readout
        trig_en = 1'b0;
        pulse_arm();
        capture_en = 1'b1;
        for (int i = 0; i < 3; i++) begin set_rec(32'(i * 4)); tick(); end
        capture_en = 1'b0;
        pulse_stop();
        chk("t1_count", {27'd0, count}, 32'd3);
        rd_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("t1_last", {31'd0, rd_last}, {31'd0, (i % 3 == 2)});
            if (i == 0) chk("t1_first", rd_data, 32'h0000_0000);
            tick();
        end
        rd_ready = 1'b0;
        chk("t1_drained", {27'd0, count}, 32'd0);

        // PC-match trigger at 0x10
        trig_en = 1'b1;
        trig_pc = 32'h10;
        pulse_arm();
        capture_en = 1'b1;
        for (int pc = 0; pc < 'h10; pc += 4) begin
            set_rec(32'(pc));
            chk("t2_armed", {30'd0, state}, 32'd1);
            tick();
        end
        set_rec(32'h10);
        tick();
        chk("t2_capture", {30'd0, state}, 32'd2);
        capture_en = 1'b0;
        pulse_stop();
        chk("t2_head", rd_data, 32'h10);
        chk("t2_count", {27'd0, count}, 32'd1);

        // Backpressure holds the beat, then one beat per cycle
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_data", rd_data, 32'h10);
            chk("t3_hold_last", {31'd0, rd_last}, 32'd0);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        chk("t3_adv_instr", rd_data, 32'hA000_0010);
        tick();
        chk("t3_adv_alu", rd_data, 32'hB000_0010);
        chk("t3_adv_last", {31'd0, rd_last}, 32'd1);
        tick();
        rd_ready = 1'b0;
        chk("t3_drained", {27'd0, count}, 32'd0);

        // Seventeen captures into a sixteen-deep buffer
        trig_en = 1'b0;
        pulse_clear();
        pulse_arm();
        capture_en = 1'b1;
        for (int i = 0; i < 17; i++) begin set_rec(32'(i * 4)); tick(); end
        capture_en = 1'b0;
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_count", {27'd0, count}, 32'd16);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);

        // Push on the same cycle as the final-beat pop of a full buffer
        rd_ready = 1'b1;
        tick();
        tick();
        capture_en = 1'b1;
        set_rec(32'h100);
        chk("t5_last", {31'd0, rd_last}, 32'd1);
        tick();
        capture_en = 1'b0;
        rd_ready   = 1'b0;
        chk("t5_count", {27'd0, count}, 32'd15);
        chk("t5_overflow", {31'd0, overflow}, 32'd1);
        pulse_stop();
        rd_ready = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            for (int b = 0; b < 3; b++) begin
                if (b == 0) chk("t5_pc", rd_data, 32'(r * 4));
                tick();
            end
        end
        rd_ready = 1'b0;
        chk("t5_drained", {27'd0, count}, 32'd0);

        // Clear with five records leaves the FSM alone
        pulse_arm();
        capture_en = 1'b1;
        for (int i = 0; i < 5; i++) begin set_rec(32'h200 + 32'(i * 4)); tick(); end
        capture_en = 1'b0;
        chk("t6_count5", {27'd0, count}, 32'd5);
        pulse_clear();
        chk("t6_clr_count", {27'd0, count}, 32'd0);
        chk("t6_clr_state", {30'd0, state}, 32'd2);

        // Asynchronous reset in the middle of a record readout
        capture_en = 1'b1;
        for (int i = 0; i < 2; i++) begin set_rec(32'h300 + 32'(i * 4)); tick(); end
        capture_en = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t6_beat2", rd_data, 32'hA000_0300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_last", {31'd0, rd_last}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_model();

        // Randomized traffic: a fill-heavy phase then a balanced phase
        for (int n = 0; n < 700; n++) begin
            arm           = ($urandom % 6 == 0);
            stop          = ($urandom % 12 == 0);
            clear         = ($urandom % 60 == 0);
            capture_en    = $urandom % 2;
            rd_ready      = (n < 300) ? ($urandom % 5 == 0) : ($urandom % 3 != 0);
            trig_en       = $urandom % 2;
            trig_pc       = 32'(($urandom % 8) * 4);
            PC_in         = 32'(($urandom % 8) * 4);
            instr_in      = $urandom;
            alu_result_in = $urandom;
            tick();
        end
        arm = 0; stop = 0; clear = 0; capture_en = 0; rd_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_trace_capture_unit
`default_nettype wire
